cam_pixel_packer: RTL and testbench

Upstream feeder for axi_master_camera. Takes the raw 8-bit camera pixel stream and packs 4 pixels per 32-bit word into an internal FIFO. Issues one burst request (address + AWLEN-encoded length) per BURST_LEN buffered words, then streams that burst's data beats with a last flag. The camera cannot be back-pressured, so words that arrive while the FIFO is full are dropped and flagged.

---
 rtl/cam_pixel_packer.sv | 173 +++++++++++++++++
 tb/tb_cam_pixel_packer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pixel_packer.sv
// Packs an 8-bit camera pixel stream into 32-bit words, buffers them and issues fixed-length bursts.
// Optional `PACKER_DROP_CNT_EN` adds a saturating drop_cnt output.
module cam_pixel_packer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FRAME_BYTES = 4096,
  parameter int          BURST_LEN   = 16,
  parameter int          FIFO_DEPTH  = 64
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  input  logic        pix_sof,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  output logic [7:0]  req_len,
  output logic        dat_valid,
  input  logic        dat_ready,
  output logic [31:0] dat_data,
  output logic        dat_last,
  output logic        overflow,
  output logic        sync_err,
  output logic        frame_done
`ifdef PACKER_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);
  localparam int FRAME_WORDS = FRAME_BYTES / 4;
  localparam int NUM_BURSTS  = FRAME_BYTES / (BURST_LEN * 4);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int FW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int LW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_e;

  state_e        state_q;
  logic [1:0]    phase_q, phase_d;
  logic [23:0]   part_q, part_d;
  logic [FW-1:0] fwords_q, fwords_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] burst_idx_q;
  logic [LW-1:0] beat_q;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic          req_valid_q, dat_valid_q, overflow_q, sync_err_q, frame_done_q;
  logic [31:0]   req_addr_q;
  logic          push, push_ok, pop, drop, sof_err;
  logic [31:0]   push_word;

  // Byte assembly; an SOF pixel restarts the word as byte 0.
  always_comb begin
    phase_d   = phase_q;
    part_d    = part_q;
    fwords_d  = fwords_q;
    push      = 1'b0;
    push_word = {pix_data, part_q};
    sof_err   = 1'b0;
    if (pix_valid) begin
      if (pix_sof) begin
        sof_err  = (phase_q != 2'd0) || (fwords_q != '0);
        part_d   = {16'h0, pix_data};
        phase_d  = 2'd1;
        fwords_d = '0;
      end else begin
        phase_d = phase_q + 2'd1;
        case (phase_q)
          2'd0:    part_d[7:0]   = pix_data;
          2'd1:    part_d[15:8]  = pix_data;
          2'd2:    part_d[23:16] = pix_data;
          default: begin
            push     = 1'b1;
            fwords_d = (fwords_q == FW'(FRAME_WORDS - 1)) ? '0 : fwords_q + FW'(1);
          end
        endcase
      end
    end
  end

  assign pop     = dat_valid_q & dat_ready;
  assign drop    = push & (count_q == CW'(FIFO_DEPTH)) & ~pop;
  assign push_ok = push & ~drop;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge ACLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= IDLE;
      phase_q      <= 2'd0;
      part_q       <= '0;
      fwords_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      burst_idx_q  <= '0;
      beat_q       <= '0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      dat_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      sync_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      part_q       <= part_d;
      fwords_q     <= fwords_d;
      count_q      <= count_d;
      frame_done_q <= 1'b0;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      if (drop)    overflow_q <= 1'b1;
      if (sof_err) sync_err_q <= 1'b1;
      case (state_q)
        IDLE: if (count_q >= CW'(BURST_LEN)) begin
          state_q     <= REQ;
          req_valid_q <= 1'b1;
          req_addr_q  <= BASE_ADDR + 32'(burst_idx_q) * 32'(BURST_LEN * 4);
        end
        REQ: if (req_ready) begin
          state_q     <= DATA;
          req_valid_q <= 1'b0;
          dat_valid_q <= 1'b1;
          beat_q      <= '0;
        end
        DATA: if (dat_ready) begin
          beat_q <= beat_q + LW'(1);
          if (beat_q == LW'(BURST_LEN - 1)) begin
            state_q     <= IDLE;
            dat_valid_q <= 1'b0;
            if (burst_idx_q == BW'(NUM_BURSTS - 1)) begin
              burst_idx_q  <= '0;
              frame_done_q <= 1'b1;
            end else begin
              burst_idx_q <= burst_idx_q + BW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PACKER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                            drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end
  assign drop_cnt = drop_cnt_q;
`endif

  assign req_valid  = req_valid_q;
  assign req_addr   = req_addr_q;
  assign req_len    = 8'(BURST_LEN - 1);
  assign dat_valid  = dat_valid_q;
  // Head is gated so the data bus reads zero outside a burst.
  assign dat_data   = dat_valid_q ? mem_q[rd_ptr_q] : '0;
  assign dat_last   = dat_valid_q && (beat_q == LW'(BURST_LEN - 1));
  assign overflow   = overflow_q;
  assign sync_err   = sync_err_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_cam_pixel_packer.sv
// Randomized bench for cam_pixel_packer with a queue-based reference model of the word stream.
module tb_cam_pixel_packer;
  localparam int BL = 16, DEPTH = 64, NB = 64, FWORDS = 1024;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        ACLK = 1'b0, ARESET = 1'b1;
  logic        pix_valid = 1'b0, pix_sof = 1'b0;
  logic [7:0]  pix_data = 8'h0;
  logic        req_valid, req_ready = 1'b0;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        dat_valid, dat_ready = 1'b0;
  logic [31:0] dat_data;
  logic        dat_last, overflow, sync_err, frame_done;
`ifdef PACKER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  cam_pixel_packer dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data), .dat_last(dat_last),
    .overflow(overflow), .sync_err(sync_err), .frame_done(frame_done)
`ifdef PACKER_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ready pattern: 0 always, 1 toggling dat_ready, 2 request stalled, 3 random
  int rmode = 0;
  always @(posedge ACLK) begin
    #1;
    case (rmode)
      0:       begin req_ready = 1'b1; dat_ready = 1'b1; end
      1:       begin req_ready = 1'b1; dat_ready = ~dat_ready; end
      2:       begin req_ready = 1'b0; dat_ready = 1'b1; end
      default: begin req_ready = 1'($urandom_range(0, 1)); dat_ready = 1'($urandom_range(0, 1)); end
    endcase
  end

  // Reference model: what the next rising edge will do, evaluated at the falling edge.
  logic [31:0] m_q[$];
  logic [31:0] beats_log[$];
  logic [7:0]  m_part[$];
  int m_fwords, m_drops, m_beat, m_burst, fd_cnt = 0, req_cnt = 0;
  bit m_ovf, m_serr, m_in_burst, m_fd_next;
  logic [31:0] last_addr = 32'hFFFF_FFFF;

  always @(negedge ACLK) begin
    logic [31:0] w;
    bit pop, push;
    if (ARESET) begin
      m_q.delete(); m_part.delete(); beats_log.delete();
      m_fwords = 0; m_drops = 0; m_beat = 0; m_burst = 0;
      m_ovf = 0; m_serr = 0; m_in_burst = 0; m_fd_next = 0;
    end else begin
      chk("overflow", overflow, 32'(m_ovf));
      chk("sync_err", sync_err, 32'(m_serr));
      chk("frame_done", frame_done, 32'(m_fd_next));
      chk("dat_valid", dat_valid, 32'(m_in_burst));
`ifdef PACKER_DROP_CNT_EN
      chk("drop_cnt", drop_cnt, 32'(m_drops));
`endif
      if (frame_done) fd_cnt++;
      m_fd_next = 0;
      if (dat_valid) begin
        if (m_q.size() == 0) chk("dat_valid_empty", dat_valid, 0);
        else                 chk("dat_data", dat_data, m_q[0]);
        chk("dat_last", dat_last, 32'(m_beat == BL - 1));
      end
      if (req_valid) begin
        chk("req_addr", req_addr, BASE + 32'(m_burst * BL * 4));
        chk("req_len", req_len, 32'(BL - 1));
        chk("req_while_burst", req_valid & m_in_burst, 0);
      end
      pop  = m_in_burst && dat_ready;
      push = 0;
      w    = '0;
      if (pix_valid) begin
        if (pix_sof) begin
          if (m_part.size() != 0 || (m_fwords % FWORDS) != 0) m_serr = 1;
          m_part.delete();
          m_fwords = 0;
        end
        m_part.push_back(pix_data);
        if (m_part.size() == 4) begin
          w = {m_part[3], m_part[2], m_part[1], m_part[0]};
          m_part.delete();
          m_fwords++;
          push = 1;
        end
      end
      if (push && m_q.size() == DEPTH && !pop) begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
        push = 0;
      end
      if (pop && m_q.size() > 0) begin
        beats_log.push_back(m_q.pop_front());
        m_beat++;
        if (m_beat == BL) begin
          m_in_burst = 0;
          m_burst = (m_burst + 1) % NB;
          if (m_burst == 0) m_fd_next = 1;
        end
      end
      if (push) m_q.push_back(w);
      if (req_valid && req_ready && !m_in_burst) begin
        m_in_burst = 1; m_beat = 0; req_cnt++; last_addr = req_addr;
      end
    end
  end

  task automatic send_pix(input logic [7:0] d, input bit sof, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(posedge ACLK); #1; pix_valid = 1'b0; pix_sof = 1'b0;
    end
    @(posedge ACLK); #1;
    pix_valid = 1'b1; pix_data = d; pix_sof = sof;
  endtask

  task automatic send_word(input logic [31:0] w, input bit sof, input bit gaps);
    for (int i = 0; i < 4; i++) send_pix(w[8*i +: 8], sof && i == 0, gaps);
  endtask

  task automatic idle(input int n);
    @(posedge ACLK); #1; pix_valid = 1'b0; pix_sof = 1'b0;
    repeat (n) @(posedge ACLK);
  endtask

  task automatic chk_rst();
    chk("rst_flags", {26'b0, req_valid, dat_valid, dat_last, overflow, sync_err, frame_done}, 0);
    chk("rst_addr", req_addr, 0);
    chk("rst_data", dat_data, 0);
    chk("rst_len", req_len, 32'(BL - 1));
`ifdef PACKER_DROP_CNT_EN
    chk("rst_drop_cnt", drop_cnt, 0);
`endif
  endtask

  task automatic do_reset();
    idle(0);
    #2 ARESET = 1'b1;
    #1 chk_rst();
    repeat (2) @(posedge ACLK);
    #2 ARESET = 1'b0;
  endtask

  int r0, f0;
  initial begin
    repeat (3) @(posedge ACLK);
    #2 chk_rst();
    ARESET = 1'b0;

    // plain packing, two bursts
    rmode = 0; r0 = req_cnt;
    for (int i = 0; i < 16; i++) send_word(32'h4433_2211, i == 0, 0);
    idle(30);
    chk("pk_reqs", req_cnt - r0, 1);
    chk("pk_addr0", last_addr, 32'h0000_1000);
    for (int i = 0; i < 16; i++) send_word(32'h4433_2211, 0, 1);
    idle(30);
    chk("pk_addr1", last_addr, 32'h0000_1040);

    // reset with 7 words buffered
    rmode = 2;
    for (int i = 0; i < 7; i++) send_word($urandom, i == 0, 1);
    do_reset();
    rmode = 0; r0 = req_cnt;
    for (int i = 0; i < 16; i++) send_word($urandom, i == 0, 1);
    idle(30);
    chk("rst_first_addr", last_addr, 32'h0000_1000);
    chk("rst_reqs", req_cnt - r0, 1);

    // full frame and wrap
    do_reset();
    rmode = 0; r0 = req_cnt; f0 = fd_cnt;
    for (int i = 0; i < FWORDS; i++) send_word($urandom, i == 0, 1);
    idle(40);
    chk("frm_reqs", req_cnt - r0, 16 * 4);
    chk("frm_done_cnt", fd_cnt - f0, 1);
    for (int i = 0; i < 16; i++) send_word($urandom, 0, 0);
    idle(30);
    chk("frm_wrap_addr", last_addr, 32'h0000_1000);
    chk("frm_done_cnt2", fd_cnt - f0, 1);

    // overflow with requests stalled
    do_reset();
    rmode = 2; r0 = req_cnt;
    for (int i = 0; i < 65; i++) send_word($urandom, i == 0, 0);
    idle(5);
    chk("ovf_flag", overflow, 1);
`ifdef PACKER_DROP_CNT_EN
    chk("ovf_drop_cnt", drop_cnt, 1);
`endif
    rmode = 0;
    idle(120);
    chk("ovf_reqs", req_cnt - r0, 4);

    // SOF on the third pixel of a word
    do_reset();
    rmode = 0;
    for (int i = 0; i < 2; i++) send_word($urandom, i == 0, 0);
    send_pix(8'h5A, 0, 0); send_pix(8'h5B, 0, 0);
    send_pix(8'hA0, 1, 0); send_pix(8'hB1, 0, 0); send_pix(8'hC2, 0, 0); send_pix(8'hD3, 0, 0);
    for (int i = 0; i < 13; i++) send_word($urandom, 0, 1);
    idle(30);
    chk("sof_err", sync_err, 1);
    chk("sof_beats", beats_log.size(), 16);
    if (beats_log.size() > 2) chk("sof_word", beats_log[2], 32'hD3C2_B1A0);

    // stalled data: toggling then random ready
    do_reset();
    rmode = 1; r0 = req_cnt;
    for (int i = 0; i < 32; i++) send_word($urandom, i == 0, 1);
    idle(80);
    rmode = 3;
    for (int i = 0; i < 48; i++) send_word($urandom, 0, 1);
    idle(150);
    chk("stall_reqs", req_cnt - r0, 5);
    chk("stall_beats", beats_log.size(), 80);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
